// File: rtl/cpu_bus_pkg.sv
// rtl/cpu_bus_pkg.sv - shared bus constants and status register layout for the CPU output port
package cpu_bus_pkg;

    localparam int BUS_DATA_W = 8;

    localparam logic [7:0] BUS_PORT_ADDR = 8'hF0;
    localparam logic [7:0] BUS_STAT_ADDR = 8'hF1;

    localparam int STAT_OVF_BIT   = 7;
    localparam int STAT_FULL_BIT  = 6;
    localparam int STAT_EMPTY_BIT = 5;
    localparam int STAT_COUNT_W   = 5;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through synchronous FIFO with register-array storage
module sync_fifo #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 4,
    localparam int PW     = $clog2(DEPTH),
    localparam int CW     = PW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              full,
    output logic              empty,
    output logic [CW-1:0]     count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              wr_en;
    logic              rd_en;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    // Full is judged on pre-edge state, so a same-cycle pop never rescues a push.
    assign wr_en     = push && !full;
    assign rd_en     = pop && !empty;
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cpu_out_port.sv
// rtl/cpu_out_port.sv - CPU bus sink: buffers port writes in a FIFO, streams them out, reports status
module cpu_out_port
    import cpu_bus_pkg::*;
#(
    parameter int         DATA_W    = BUS_DATA_W,
    parameter int         DEPTH     = 4,
    parameter logic [7:0] PORT_ADDR = BUS_PORT_ADDR,
    parameter logic [7:0] STAT_ADDR = BUS_STAT_ADDR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        bus_addr,
    input  logic [DATA_W-1:0] bus_data,
    input  logic              bus_we,
    input  logic              bus_re,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overflow
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic              push_req;
    logic              stat_wr;
    logic              stat_rd;
    logic              pop;
    logic              full;
    logic              empty;
    logic [CW-1:0]     count;
    logic [DATA_W-1:0] status;

    assign push_req  = bus_we && (bus_addr == PORT_ADDR);
    assign stat_wr   = bus_we && (bus_addr == STAT_ADDR);
    assign stat_rd   = bus_re && (bus_addr == STAT_ADDR);
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_req),
        .push_data (bus_data),
        .pop       (pop),
        .head_data (out_data),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    always_comb begin
        status                      = '0;
        status[STAT_COUNT_W-1:0]    = STAT_COUNT_W'(count);
        status[STAT_EMPTY_BIT]      = empty;
        status[STAT_FULL_BIT]       = full;
        status[STAT_OVF_BIT]        = overflow;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            // A dropped push outranks a same-cycle clear so no loss goes unreported.
            if (push_req && full) begin
                overflow <= 1'b1;
            end else if (stat_wr) begin
                overflow <= 1'b0;
            end
            rd_valid <= stat_rd;
            if (stat_rd) begin
                rd_data <= status;
            end
        end
    end

endmodule

// File: tb/tb_cpu_out_port.sv
// tb/tb_cpu_out_port.sv - directed self-checking bench for cpu_out_port
module tb_cpu_out_port;

    logic       clk;
    logic       rst;
    logic [7:0] bus_addr;
    logic [7:0] bus_data;
    logic       bus_we;
    logic       bus_re;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       overflow;

    int checks;
    int errors;

    cpu_out_port dut (
        .clk       (clk),
        .rst       (rst),
        .bus_addr  (bus_addr),
        .bus_data  (bus_data),
        .bus_we    (bus_we),
        .bus_re    (bus_re),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d);
        bus_we   = 1'b1;
        bus_addr = 8'hF0;
        bus_data = d;
        tick();
        bus_we   = 1'b0;
    endtask

    task automatic read_status(output logic [7:0] d, output logic v);
        bus_re   = 1'b1;
        bus_addr = 8'hF1;
        tick();
        d        = rd_data;
        v        = rd_valid;
        bus_re   = 1'b0;
    endtask

    task automatic clear_overflow();
        bus_we   = 1'b1;
        bus_addr = 8'hF1;
        bus_data = 8'h00;
        tick();
        bus_we   = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] s;
        logic       v;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_overflow: got %b expected 0", overflow);
        end
        read_status(s, v);
        checks++;
        if (v !== 1'b1 || s !== 8'h20) begin
            errors++;
            $display("FAIL reset_status: got valid=%b data=%h expected valid=1 data=20", v, s);
        end
        tick();
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL rd_valid_pulse: got %b expected 0", rd_valid);
        end
    endtask

    task automatic test_fwft_order();
        logic [7:0] exp [3];
        exp[0] = 8'h11;
        exp[1] = 8'h22;
        exp[2] = 8'h33;
        out_ready = 1'b0;
        push_byte(8'h11);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h11) begin
            errors++;
            $display("FAIL push_latency: got valid=%b data=%h expected valid=1 data=11", out_valid, out_data);
        end
        push_byte(8'h22);
        push_byte(8'h33);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp[i]) begin
                errors++;
                $display("FAIL drain_%0d: got valid=%b data=%h expected valid=1 data=%h", i, out_valid, out_data, exp[i]);
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty: got %b expected 0", out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_overflow();
        logic [7:0] s;
        logic       v;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_byte(8'hA0 + 8'(i));
        end
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_set: got %b expected 1", overflow);
        end
        read_status(s, v);
        checks++;
        if (v !== 1'b1 || s !== 8'hC4) begin
            errors++;
            $display("FAIL full_status: got valid=%b data=%h expected valid=1 data=c4", v, s);
        end
        clear_overflow();
        checks++;
        if (overflow !== 1'b0 || out_data !== 8'hA0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL overflow_clear: got ovf=%b valid=%b data=%h expected ovf=0 valid=1 data=a0", overflow, out_valid, out_data);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_data !== 8'hA0 + 8'(i)) begin
                errors++;
                $display("FAIL overflow_drain_%0d: got %h expected %h", i, out_data, 8'hA0 + 8'(i));
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL overflow_fifth_dropped: got valid=%b expected 0", out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_full_push_pop();
        logic [7:0] s;
        logic       v;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_byte(8'hB0 + 8'(i));
        end
        out_ready = 1'b1;
        push_byte(8'hB4);
        out_ready = 1'b0;
        read_status(s, v);
        checks++;
        if (s !== 8'h83 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL full_push_pop_status: got status=%h ovf=%b expected status=83 ovf=1", s, overflow);
        end
        out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'hB0 + 8'(i)) begin
                errors++;
                $display("FAIL full_push_pop_drain_%0d: got valid=%b data=%h expected valid=1 data=%h", i, out_valid, out_data, 8'hB0 + 8'(i));
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_push_pop_empty: got %b expected 0", out_valid);
        end
        out_ready = 1'b0;
        clear_overflow();
    endtask

    task automatic test_back_to_back();
        logic [7:0] s;
        logic       v;
        out_ready = 1'b0;
        push_byte(8'hC0);
        out_ready = 1'b1;
        bus_we    = 1'b1;
        bus_addr  = 8'hF0;
        for (int i = 0; i < 10; i++) begin
            bus_data = 8'hC1 + 8'(i);
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'hC0 + 8'(i)) begin
                errors++;
                $display("FAIL stream_%0d: got valid=%b data=%h expected valid=1 data=%h", i, out_valid, out_data, 8'hC0 + 8'(i));
            end
            tick();
        end
        bus_we    = 1'b0;
        out_ready = 1'b0;
        read_status(s, v);
        checks++;
        if (s !== 8'h01 || out_data !== 8'hCA) begin
            errors++;
            $display("FAIL stream_end: got status=%h data=%h expected status=01 data=ca", s, out_data);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_other_addr();
        logic [7:0] s;
        logic       v;
        read_status(s, v);
        checks++;
        if (s !== 8'h20) begin
            errors++;
            $display("FAIL idle_status: got %h expected 20", s);
        end
        bus_re   = 1'b1;
        bus_addr = 8'hF0;
        tick();
        bus_re   = 1'b0;
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 8'h20) begin
            errors++;
            $display("FAIL other_read: got valid=%b data=%h expected valid=0 data=20", rd_valid, rd_data);
        end
        bus_we   = 1'b1;
        bus_addr = 8'h55;
        bus_data = 8'h77;
        tick();
        bus_we   = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL other_write: got valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_reset_mid_stream();
        logic [7:0] s;
        logic       v;
        out_ready = 1'b0;
        push_byte(8'hD0);
        push_byte(8'hD1);
        push_byte(8'hD2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_out_valid: got %b expected 0", out_valid);
        end
        read_status(s, v);
        checks++;
        if (v !== 1'b1 || s !== 8'h20) begin
            errors++;
            $display("FAIL midreset_status: got valid=%b data=%h expected valid=1 data=20", v, s);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        bus_addr  = 8'h00;
        bus_data  = 8'h00;
        bus_we    = 1'b0;
        bus_re    = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_fwft_order();
        test_overflow();
        test_full_push_pop();
        test_back_to_back();
        test_other_addr();
        test_reset_mid_stream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
